ws281x_decode: RTL

- Receive-side counterpart of the WS281x code generator: samples a WS281x single-wire stream, classifies each bit by its high-pulse width and assembles MSB-first 24-bit pixels.
- Emits a write strobe with a pixel address for a frame RAM, and flags frame end on a reset (long-low) period.
- Used as a loopback checker for the transmit chain and as a chained-strip input stage.

---
 rtl/ws281x_decode.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ws281x_decode.sv
// ws281x_decode: WS281x single-wire receiver.
// Classifies each high pulse against a width threshold, assembles MSB-first
// 24-bit pixels, strobes them out with a frame-RAM address, and signals frame
// end when the line stays low for the reset period.
// Optional macro WS281X_DECODE_ERR_EN adds a sticky decode_err_out flag.
module ws281x_decode #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  ws281x_code_in,
    input  logic [7:0]            bit_thr_cnt_in,
    input  logic [CNT_WIDTH-1:0]  rst_cnt_in,
    output logic                  pixel_valid_out,
    output logic [ADDR_WIDTH-1:0] pixel_addr_out,
    output logic [23:0]           pixel_data_out,
    output logic                  frame_done_out
`ifdef WS281X_DECODE_ERR_EN
    ,
    output logic                  decode_err_out
`endif
);

    typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_HIGH, ST_LOW} state_t;

    state_t                state_q, state_d;
    logic [2:0]            sync_q, sync_d;
    logic [7:0]            high_cnt_q, high_cnt_d;
    logic [CNT_WIDTH-1:0]  low_cnt_q, low_cnt_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [23:0]           shift_q, shift_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  any_bit_q, any_bit_d;
    logic                  fd_pend_q, fd_pend_d;
    logic                  pixel_valid_q, pixel_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic [23:0]           data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic                  s2, rise, fall, timeout, pix_done, frame_end;
    logic [CNT_WIDTH-1:0]  rst_lim;

    assign s2       = sync_q[1];
    assign rise     = sync_q[1] & ~sync_q[2];
    assign fall     = ~sync_q[1] & sync_q[2];
    assign rst_lim  = (rst_cnt_in == '0) ? CNT_WIDTH'(1) : rst_cnt_in;
    assign timeout  = (low_cnt_q >= rst_lim);
    assign pix_done = (bit_cnt_q == 5'd24);
    // A frame end that coincides with a pixel strobe is held one cycle (fd_pend_q)
    assign frame_end = ((state_q == ST_LOW) && !rise && timeout) || fd_pend_q;

    // Next-state: synchroniser shift, pulse counters, FSM, pixel and frame-end handling
    always_comb begin
        sync_d        = {sync_q[1:0], ws281x_code_in};
        state_d       = state_q;
        high_cnt_d    = high_cnt_q;
        low_cnt_d     = low_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        idx_d         = idx_q;
        any_bit_d     = any_bit_q;
        fd_pend_d     = 1'b0;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        data_d        = data_q;
        addr_d        = addr_q;

        if (rise) begin
            high_cnt_d = '0;
        end else if (state_q == ST_HIGH && high_cnt_q != '1) begin
            high_cnt_d = high_cnt_q + 8'd1;
        end

        if (fall || (state_q == ST_SYNC && s2)) begin
            low_cnt_d = '0;
        end else if ((state_q == ST_LOW || state_q == ST_SYNC) && low_cnt_q != '1) begin
            low_cnt_d = low_cnt_q + 1'b1;
        end

        case (state_q)
            ST_SYNC: if (!s2 && timeout) state_d = ST_IDLE;
            ST_IDLE: if (rise) state_d = ST_HIGH;
            ST_HIGH: begin
                if (fall) begin
                    shift_d   = {shift_q[22:0], (high_cnt_q > bit_thr_cnt_in)};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    any_bit_d = 1'b1;
                    state_d   = ST_LOW;
                end
            end
            ST_LOW: begin
                if (rise)         state_d = ST_HIGH;
                else if (timeout) state_d = ST_IDLE;
            end
            default: state_d = ST_SYNC;
        endcase

        if (pix_done) begin
            pixel_valid_d = 1'b1;
            data_d        = shift_q;
            addr_d        = idx_q;
            idx_d         = idx_q + 1'b1;
            bit_cnt_d     = '0;
        end

        if (frame_end) begin
            if (pix_done) begin
                fd_pend_d = 1'b1;
            end else begin
                frame_done_d = any_bit_q;
                any_bit_d    = 1'b0;
                bit_cnt_d    = '0;
                idx_d        = '0;
            end
        end
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_SYNC;
            sync_q        <= '0;
            high_cnt_q    <= '0;
            low_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            idx_q         <= '0;
            any_bit_q     <= 1'b0;
            fd_pend_q     <= 1'b0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            data_q        <= '0;
            addr_q        <= '0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            high_cnt_q    <= high_cnt_d;
            low_cnt_q     <= low_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            idx_q         <= idx_d;
            any_bit_q     <= any_bit_d;
            fd_pend_q     <= fd_pend_d;
            pixel_valid_q <= pixel_valid_d;
            frame_done_q  <= frame_done_d;
            data_q        <= data_d;
            addr_q        <= addr_d;
        end
    end

    assign pixel_valid_out = pixel_valid_q;
    assign pixel_addr_out  = addr_q;
    assign pixel_data_out  = data_q;
    assign frame_done_out  = frame_done_q;

`ifdef WS281X_DECODE_ERR_EN
    logic err_q, err_d, err_set, trunc;

    // Sticky error: saturated high pulse, runt low, truncated pixel; a frame_done restarts it
    always_comb begin
        trunc   = frame_end && !pix_done && (bit_cnt_q != '0);
        err_set = ((state_q == ST_HIGH) && (high_cnt_q == '1)) ||
                  ((state_q == ST_LOW) && rise && (low_cnt_q < CNT_WIDTH'(2)));
        if (frame_done_d) err_d = trunc | err_set;
        else              err_d = err_q | trunc | err_set;
    end

    // Error flag register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign decode_err_out = err_q;
`endif

endmodule
